// File: rtl/attention_dot_engine_if.sv
// Stream bundle for the attention dot-product engine: q/k element input
// stream and saturated score output stream.
interface attention_dot_engine_if #(
    parameter int DATA_W = 8,
    parameter int OUT_W  = 8
);
    logic signed [DATA_W-1:0] slv_data_in;
    logic                     slv_vld_in;
    logic                     slv_rdy_out;
    logic signed [OUT_W-1:0]  mst_data_out;
    logic                     mst_vld_out;
    logic                     mst_rdy_in;
    logic                     mst_sat_out;

    // Engine side: consumes the element stream, produces scores.
    modport slave (
        input  slv_data_in, slv_vld_in, mst_rdy_in,
        output slv_rdy_out, mst_data_out, mst_vld_out, mst_sat_out
    );

    // Environment side: produces elements, consumes scores.
    modport master (
        output slv_data_in, slv_vld_in, mst_rdy_in,
        input  slv_rdy_out, mst_data_out, mst_vld_out, mst_sat_out
    );
endinterface

// File: rtl/attention_dot_engine.sv
// Dot-product score engine: MACs interleaved q/k elements, scales by an
// arithmetic right shift, saturates to OUT_W and holds the score in a one-entry buffer.
module attention_dot_engine #(
    parameter int DATA_W   = 8,
    parameter int NUM_FEAT = 4,
    parameter int SHIFT    = 1,
    parameter int OUT_W    = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    attention_dot_engine_if.slave bus
);
    localparam int LOG_FEAT = (NUM_FEAT > 1) ? $clog2(NUM_FEAT) : 1;
    localparam int ACC_W    = 2 * DATA_W + LOG_FEAT;
    localparam int CNT_W    = LOG_FEAT;
    localparam int PROD_W   = 2 * DATA_W;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_FEAT - 1);

    typedef enum logic {
        LOAD_Q,
        LOAD_K
    } phase_t;

    phase_t                   phase_reg, phase_next;
    logic [CNT_W-1:0]         feat_cnt_reg, feat_cnt_next;
    logic [DATA_W-1:0]        q_reg, q_next;
    logic signed [ACC_W-1:0]  acc_reg, acc_next;
    logic [OUT_W-1:0]         out_buf_reg, out_buf_next;
    logic                     out_sat_reg, out_sat_next;
    logic                     out_vld_reg, out_vld_next;

    logic                     last_beat;
    logic                     slv_rdy;
    logic                     beat;
    logic [PROD_W-1:0]        q_ext;
    logic [PROD_W-1:0]        d_ext;
    logic [PROD_W-1:0]        prod;
    logic signed [ACC_W-1:0]  acc_sum;
    logic signed [ACC_W-1:0]  sum_shift;
    logic [OUT_W-1:0]         clip_val;
    logic                     clip_sat;

    // Operands sign-extended to full product width so an unsigned multiply yields the signed product bits.
    assign q_ext     = {{DATA_W{q_reg[DATA_W-1]}}, q_reg};
    assign d_ext     = {{DATA_W{bus.slv_data_in[DATA_W-1]}}, bus.slv_data_in};
    assign prod      = q_ext * d_ext;
    assign acc_sum   = acc_reg + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    assign sum_shift = acc_sum >>> SHIFT;

    generate
        if (OUT_W < ACC_W) begin : gen_clip
            localparam logic signed [ACC_W-1:0] OUT_MAX = (ACC_W'(1) << (OUT_W - 1)) - ACC_W'(1);
            localparam logic signed [ACC_W-1:0] OUT_MIN = ~OUT_MAX;
            logic sat_hi;
            logic sat_lo;
            assign sat_hi   = sum_shift > OUT_MAX;
            assign sat_lo   = sum_shift < OUT_MIN;
            assign clip_sat = sat_hi | sat_lo;
            assign clip_val = sat_hi ? OUT_MAX[OUT_W-1:0]
                            : sat_lo ? OUT_MIN[OUT_W-1:0]
                            : sum_shift[OUT_W-1:0];
        end else begin : gen_wide
            assign clip_sat = 1'b0;
            assign clip_val = OUT_W'(sum_shift);
        end
    endgenerate

    // Only the final k beat can stall, and only while an undrained score occupies the buffer.
    assign last_beat = (phase_reg == LOAD_K) && (feat_cnt_reg == LAST_CNT);
    assign slv_rdy   = !(last_beat && out_vld_reg && !bus.mst_rdy_in);
    assign beat      = bus.slv_vld_in && slv_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_reg    <= LOAD_Q;
            feat_cnt_reg <= '0;
            q_reg        <= '0;
            acc_reg      <= '0;
            out_buf_reg  <= '0;
            out_sat_reg  <= 1'b0;
            out_vld_reg  <= 1'b0;
        end else begin
            phase_reg    <= phase_next;
            feat_cnt_reg <= feat_cnt_next;
            q_reg        <= q_next;
            acc_reg      <= acc_next;
            out_buf_reg  <= out_buf_next;
            out_sat_reg  <= out_sat_next;
            out_vld_reg  <= out_vld_next;
        end
    end

    always_comb begin
        phase_next    = phase_reg;
        feat_cnt_next = feat_cnt_reg;
        q_next        = q_reg;
        acc_next      = acc_reg;
        out_buf_next  = out_buf_reg;
        out_sat_next  = out_sat_reg;
        out_vld_next  = out_vld_reg;

        if (out_vld_reg && bus.mst_rdy_in) begin
            out_vld_next = 1'b0;
        end

        // A last-beat load in the same cycle overrides the drain above.
        if (beat) begin
            case (phase_reg)
                LOAD_Q: begin
                    q_next     = bus.slv_data_in;
                    phase_next = LOAD_K;
                end
                LOAD_K: begin
                    phase_next = LOAD_Q;
                    if (feat_cnt_reg == LAST_CNT) begin
                        out_buf_next  = clip_val;
                        out_sat_next  = clip_sat;
                        out_vld_next  = 1'b1;
                        acc_next      = '0;
                        feat_cnt_next = '0;
                    end else begin
                        acc_next      = acc_sum;
                        feat_cnt_next = feat_cnt_reg + CNT_W'(1);
                    end
                end
                default: phase_next = LOAD_Q;
            endcase
        end
    end

    assign bus.slv_rdy_out  = slv_rdy;
    assign bus.mst_data_out = out_buf_reg;
    assign bus.mst_sat_out  = out_sat_reg;
    assign bus.mst_vld_out  = out_vld_reg;

endmodule

// File: tb/tb_attention_dot_engine.sv
// Directed and randomized-handshake checks of attention_dot_engine for the
// default configuration and for DATA_W=6, NUM_FEAT=8, SHIFT=3, OUT_W=10.
module tb_attention_dot_engine;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    attention_dot_engine_if #(.DATA_W(8), .OUT_W(8))  bus ();
    attention_dot_engine_if #(.DATA_W(6), .OUT_W(10)) bus_r ();

    attention_dot_engine #(.DATA_W(8), .NUM_FEAT(4), .SHIFT(1), .OUT_W(8)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    attention_dot_engine #(.DATA_W(6), .NUM_FEAT(8), .SHIFT(3), .OUT_W(10)) u_dut_r (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_r)
    );

    typedef int vec4_t [4];

    int assertions = 0;
    int failures   = 0;

    int exp_data_q[$];
    int exp_sat_q[$];
    int rnd_sent;
    int rnd_received;
    localparam int RND_VECTORS = 24;

    // One accepted beat on the default instance; caller guarantees slv_rdy_out is high.
    task automatic send_beat(input int d);
        bus.slv_data_in = 8'(d);
        bus.slv_vld_in  = 1'b1;
        @(posedge clk);
        #1;
        bus.slv_vld_in  = 1'b0;
    endtask

    task automatic send_vec(input vec4_t q, input vec4_t k, input int nbeats);
        for (int b = 0; b < nbeats; b++) begin
            send_beat((b % 2 == 0) ? q[b/2] : k[b/2]);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        assertions++;
        if (bus.slv_rdy_out !== 1'b1) begin failures++; $display("FAIL reset_slv_rdy: got %b expected 1", bus.slv_rdy_out); end
        assertions++;
        if (bus.mst_vld_out !== 1'b0) begin failures++; $display("FAIL reset_mst_vld: got %b expected 0", bus.mst_vld_out); end
        assertions++;
        if (bus.mst_data_out !== 8'sd0) begin failures++; $display("FAIL reset_mst_data: got %0d expected 0", bus.mst_data_out); end
        assertions++;
        if (bus.mst_sat_out !== 1'b0) begin failures++; $display("FAIL reset_mst_sat: got %b expected 0", bus.mst_sat_out); end
        assertions++;
        if (bus_r.mst_vld_out !== 1'b0 || bus_r.slv_rdy_out !== 1'b1) begin
            failures++; $display("FAIL reset_wide_inst: vld %b rdy %b expected 0 1", bus_r.mst_vld_out, bus_r.slv_rdy_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        $display("reset released");
    endtask

    task automatic test_basic();
        vec4_t q = '{1, 2, 3, 4};
        vec4_t k = '{5, 6, 7, 8};
        bus.mst_rdy_in = 1'b1;
        for (int b = 0; b < 8; b++) begin
            assertions++;
            if (bus.slv_rdy_out !== 1'b1) begin failures++; $display("FAIL basic_rdy beat %0d: got %b expected 1", b, bus.slv_rdy_out); end
            send_beat((b % 2 == 0) ? q[b/2] : k[b/2]);
            if (b == 6) begin
                assertions++;
                if (bus.mst_vld_out !== 1'b0) begin failures++; $display("FAIL basic_early_vld: got %b expected 0", bus.mst_vld_out); end
            end
        end
        assertions++;
        if (bus.mst_vld_out !== 1'b1) begin failures++; $display("FAIL basic_vld: got %b expected 1", bus.mst_vld_out); end
        assertions++;
        if (bus.mst_data_out !== 8'sd35) begin failures++; $display("FAIL basic_data: got %0d expected 35", bus.mst_data_out); end
        assertions++;
        if (bus.mst_sat_out !== 1'b0) begin failures++; $display("FAIL basic_sat: got %b expected 0", bus.mst_sat_out); end
        $display("basic score %0d sat %b", bus.mst_data_out, bus.mst_sat_out);
        @(posedge clk);
        #1;
        assertions++;
        if (bus.mst_vld_out !== 1'b0) begin failures++; $display("FAIL basic_drain: got %b expected 0", bus.mst_vld_out); end
    endtask

    task automatic test_saturation();
        vec4_t qn = '{-128, -128, -128, -128};
        vec4_t kp = '{127, 127, 127, 127};
        bus.mst_rdy_in = 1'b1;
        send_vec(qn, qn, 8);
        assertions++;
        if (bus.mst_vld_out !== 1'b1 || bus.mst_data_out !== 8'sd127 || bus.mst_sat_out !== 1'b1) begin
            failures++; $display("FAIL sat_pos: vld %b data %0d sat %b expected 1 127 1", bus.mst_vld_out, bus.mst_data_out, bus.mst_sat_out);
        end
        $display("sat_pos score %0d sat %b", bus.mst_data_out, bus.mst_sat_out);
        send_vec(qn, kp, 8);
        assertions++;
        if (bus.mst_vld_out !== 1'b1 || bus.mst_data_out !== 8'h80 || bus.mst_sat_out !== 1'b1) begin
            failures++; $display("FAIL sat_neg: vld %b data %0d sat %b expected 1 -128 1", bus.mst_vld_out, bus.mst_data_out, bus.mst_sat_out);
        end
        $display("sat_neg score %0d sat %b", bus.mst_data_out, bus.mst_sat_out);
        @(posedge clk);
        #1;
    endtask

    task automatic test_floor();
        vec4_t q = '{-3, 0, 0, 0};
        vec4_t k = '{1, 0, 0, 0};
        bus.mst_rdy_in = 1'b1;
        send_vec(q, k, 8);
        assertions++;
        if (bus.mst_vld_out !== 1'b1 || bus.mst_data_out !== -8'sd2 || bus.mst_sat_out !== 1'b0) begin
            failures++; $display("FAIL floor: vld %b data %0d sat %b expected 1 -2 0", bus.mst_vld_out, bus.mst_data_out, bus.mst_sat_out);
        end
        $display("floor score %0d sat %b", bus.mst_data_out, bus.mst_sat_out);
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        vec4_t qa = '{1, 2, 3, 4};
        vec4_t ka = '{5, 6, 7, 8};
        vec4_t qb = '{-3, 0, 0, 0};
        vec4_t kb = '{1, 0, 0, 0};
        bus.mst_rdy_in = 1'b0;
        send_vec(qa, ka, 8);
        assertions++;
        if (bus.mst_vld_out !== 1'b1 || bus.mst_data_out !== 8'sd35) begin
            failures++; $display("FAIL b2b_first: vld %b data %0d expected 1 35", bus.mst_vld_out, bus.mst_data_out);
        end
        for (int b = 0; b < 7; b++) begin
            assertions++;
            if (bus.slv_rdy_out !== 1'b1 || bus.mst_data_out !== 8'sd35 || bus.mst_vld_out !== 1'b1) begin
                failures++; $display("FAIL b2b_hold beat %0d: rdy %b vld %b data %0d expected 1 1 35", b, bus.slv_rdy_out, bus.mst_vld_out, bus.mst_data_out);
            end
            send_beat((b % 2 == 0) ? qb[b/2] : kb[b/2]);
        end
        bus.slv_data_in = 8'(kb[3]);
        bus.slv_vld_in  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            assertions++;
            if (bus.slv_rdy_out !== 1'b0 || bus.mst_data_out !== 8'sd35 || bus.mst_vld_out !== 1'b1) begin
                failures++; $display("FAIL b2b_stall cycle %0d: rdy %b vld %b data %0d expected 0 1 35", c, bus.slv_rdy_out, bus.mst_vld_out, bus.mst_data_out);
            end
            if (c < 2) begin
                @(posedge clk);
                #1;
            end
        end
        bus.mst_rdy_in = 1'b1;
        #1;
        assertions++;
        if (bus.slv_rdy_out !== 1'b1) begin failures++; $display("FAIL b2b_rdy_comb: got %b expected 1", bus.slv_rdy_out); end
        $display("b2b score %0d drained", bus.mst_data_out);
        @(posedge clk);
        #1;
        bus.slv_vld_in = 1'b0;
        assertions++;
        if (bus.mst_vld_out !== 1'b1 || bus.mst_data_out !== -8'sd2 || bus.mst_sat_out !== 1'b0) begin
            failures++; $display("FAIL b2b_second: vld %b data %0d sat %b expected 1 -2 0", bus.mst_vld_out, bus.mst_data_out, bus.mst_sat_out);
        end
        $display("b2b score %0d sat %b", bus.mst_data_out, bus.mst_sat_out);
        @(posedge clk);
        #1;
        assertions++;
        if (bus.mst_vld_out !== 1'b0) begin failures++; $display("FAIL b2b_drain: got %b expected 0", bus.mst_vld_out); end
    endtask

    task automatic test_reset_mid();
        vec4_t qa = '{1, 2, 3, 4};
        vec4_t ka = '{5, 6, 7, 8};
        vec4_t qj = '{9, 9, 9, 9};
        vec4_t kj = '{-7, -7, -7, -7};
        bus.mst_rdy_in = 1'b0;
        send_vec(qa, ka, 8);
        send_vec(qj, kj, 5);
        #2;
        rst_n = 1'b0;
        #1;
        assertions++;
        if (bus.mst_vld_out !== 1'b0 || bus.mst_data_out !== 8'sd0 || bus.mst_sat_out !== 1'b0 || bus.slv_rdy_out !== 1'b1) begin
            failures++; $display("FAIL reset_mid_async: vld %b data %0d sat %b rdy %b expected 0 0 0 1",
                                 bus.mst_vld_out, bus.mst_data_out, bus.mst_sat_out, bus.slv_rdy_out);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bus.mst_rdy_in = 1'b1;
        @(posedge clk);
        #1;
        send_vec(qa, ka, 7);
        assertions++;
        if (bus.mst_vld_out !== 1'b0) begin failures++; $display("FAIL reset_mid_early: got vld %b expected 0", bus.mst_vld_out); end
        send_beat(ka[3]);
        assertions++;
        if (bus.mst_vld_out !== 1'b1 || bus.mst_data_out !== 8'sd35) begin
            failures++; $display("FAIL reset_mid_fresh: vld %b data %0d expected 1 35", bus.mst_vld_out, bus.mst_data_out);
        end
        $display("reset_mid score %0d", bus.mst_data_out);
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        rnd_sent     = 0;
        rnd_received = 0;
        exp_data_q.delete();
        exp_sat_q.delete();
        fork
            begin : drv
                int beat = 0;
                int acc  = 0;
                int qv   = 0;
                int dv;
                int s;
                int dcyc = 0;
                bit v;
                while (rnd_sent < RND_VECTORS && dcyc < 20000) begin
                    @(posedge clk);
                    #1;
                    v  = ($urandom_range(0, 3) != 0);
                    dv = int'($urandom_range(0, 63)) - 32;
                    if ($urandom_range(0, 5) == 0) dv = -32;
                    bus_r.slv_vld_in  = v;
                    bus_r.slv_data_in = 6'(dv);
                    @(negedge clk);
                    dcyc++;
                    if (v && bus_r.slv_rdy_out === 1'b1) begin
                        if (beat % 2 == 0) qv = dv;
                        else acc += qv * dv;
                        if (beat == 15) begin
                            s = acc >>> 3;
                            if (s > 511) begin exp_data_q.push_back(511); exp_sat_q.push_back(1); end
                            else if (s < -512) begin exp_data_q.push_back(-512); exp_sat_q.push_back(1); end
                            else begin exp_data_q.push_back(s); exp_sat_q.push_back(0); end
                            acc  = 0;
                            beat = 0;
                            rnd_sent++;
                        end else begin
                            beat++;
                        end
                    end
                end
                @(posedge clk);
                #1;
                bus_r.slv_vld_in = 1'b0;
            end
            begin : mon
                int cyc = 0;
                int ed;
                int es;
                while (rnd_received < RND_VECTORS && cyc < 20000) begin
                    @(posedge clk);
                    #1;
                    bus_r.mst_rdy_in = ((cyc % 64) < 24) ? 1'b0 : ($urandom_range(0, 1) == 1);
                    @(negedge clk);
                    if (bus_r.mst_vld_out === 1'b1 && bus_r.mst_rdy_in) begin
                        assertions++;
                        if (exp_data_q.size() == 0) begin
                            failures++; $display("FAIL random_extra: got score %0d with nothing expected", bus_r.mst_data_out);
                        end else begin
                            ed = exp_data_q.pop_front();
                            es = exp_sat_q.pop_front();
                            if (bus_r.mst_data_out !== 10'(ed) || bus_r.mst_sat_out !== 1'(es)) begin
                                failures++; $display("FAIL random_score %0d: got %0d sat %b expected %0d sat %0d",
                                                     rnd_received, bus_r.mst_data_out, bus_r.mst_sat_out, ed, es);
                            end else begin
                                $display("random score %0d: %0d sat %b", rnd_received, bus_r.mst_data_out, bus_r.mst_sat_out);
                            end
                        end
                        rnd_received++;
                    end
                    cyc++;
                end
            end
        join
        assertions++;
        if (rnd_received != RND_VECTORS || rnd_sent != RND_VECTORS) begin
            failures++; $display("FAIL random_count: sent %0d received %0d expected %0d", rnd_sent, rnd_received, RND_VECTORS);
        end
        bus_r.mst_rdy_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        assertions++;
        if (bus_r.mst_vld_out !== 1'b0 || exp_data_q.size() != 0) begin
            failures++; $display("FAIL random_leftover: vld %b pending %0d expected 0 0", bus_r.mst_vld_out, exp_data_q.size());
        end
    endtask

    initial begin
        rst_n             = 1'b0;
        bus.slv_data_in   = '0;
        bus.slv_vld_in    = 1'b0;
        bus.mst_rdy_in    = 1'b0;
        bus_r.slv_data_in = '0;
        bus_r.slv_vld_in  = 1'b0;
        bus_r.mst_rdy_in  = 1'b0;

        test_reset();
        test_basic();
        test_saturation();
        test_floor();
        test_back_to_back();
        test_reset_mid();
        test_random();

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule

// File: doc/attention_dot_engine.md
# attention_dot_engine

Parametrised dot-product score engine for the attention datapath. Accepts a valid/ready stream of interleaved signed query/key elements, multiply-accumulates NUM_FEAT products per score, scales the sum by an arithmetic right shift and saturates it to OUT_W. Each score is placed in a one-entry output buffer behind a valid/ready master port, so the next vector accumulates while the previous score waits. Sits between the input pin interface and the downstream e^x stage.

## Interface

- DATA_W, 8: signed width of each q/k element.
- NUM_FEAT, 4: products per score, ≥1.
- SHIFT, 1: arithmetic right shift applied to the sum, 0 ≤ SHIFT < ACC_W.
- OUT_W, 8: signed width of the output score.
- ACC_W (localparam) = 2*DATA_W + $clog2(NUM_FEAT), minimum 2*DATA_W+1.

- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- slv_data_in  in  DATA_W  signed q or k element.
- slv_vld_in  in  1  slave valid.
- slv_rdy_out  out  1  slave ready.
- mst_data_out  out  OUT_W  signed saturated score.
- mst_vld_out  out  1  master valid.
- mst_rdy_in  in  1  master ready.
- mst_sat_out  out  1  the held score was clipped; qualified by mst_vld_out.

## Operation

- Beat order per vector: q0, k0, q1, k1, …, q(N-1), k(N-1). A beat transfers when slv_vld_in && slv_rdy_out at a rising edge.
- State: phase ∈ {LOAD_Q, LOAD_K}; feat_cnt 0..NUM_FEAT-1; q_reg (DATA_W); acc (ACC_W signed); out_buf (OUT_W), out_sat, out_vld.
- LOAD_Q + beat: q_reg ← data; phase ← LOAD_K.
- LOAD_K + beat, feat_cnt < NUM_FEAT-1: acc ← acc + q_reg*data (full 2*DATA_W signed product, sign-extended); feat_cnt++; phase ← LOAD_Q.
- LOAD_K + beat, feat_cnt == NUM_FEAT-1 (last beat): sum = acc + q_reg*data; s = sum >>> SHIFT (floor); out_buf ← clip(s) to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; out_sat ← (s outside that range); out_vld ← 1; acc ← 0; feat_cnt ← 0; phase ← LOAD_Q.
- acc never overflows: ACC_W covers NUM_FEAT × (-2^(DATA_W-1))².
- Output drains when out_vld && mst_rdy_in; out_vld ← 0 unless a new last beat loads in the same cycle (load wins, out_vld stays 1).
- slv_rdy_out = !(phase==LOAD_K && feat_cnt==NUM_FEAT-1 && out_vld && !mst_rdy_in). All non-final beats are always accepted; only the last k beat stalls on a full, undrained buffer. Combinational path mst_rdy_in → slv_rdy_out is intentional.
- mst_data_out/mst_sat_out are stable while mst_vld_out && !mst_rdy_in.

## Timing

- Reset (async assert, sync release at clk): phase=LOAD_Q, feat_cnt=0, acc=0, q_reg=0, out_buf=0, out_sat=0, out_vld=0. Outputs: slv_rdy_out=1, mst_vld_out=0, mst_data_out=0, mst_sat_out=0.
- Reset mid-vector discards partial acc and any undelivered score; no output after release until a full 2*NUM_FEAT beats arrive.
- Latency: last k beat accepted at edge E → mst_vld_out=1 after E; with mst_rdy_in held high, drains at E+1.
- Throughput: one beat per cycle; one score per 2*NUM_FEAT cycles with no backpressure.
- Simultaneous drain and last-beat load: accepted, new score replaces old with no bubble.
- Gaps (slv_vld_in low) in any phase hold all state.

## Test plan

- Defaults, q=(1,2,3,4), k=(5,6,7,8), mst_rdy_in=1 -> sum 70, mst_data_out=35, mst_sat_out=0, mst_vld_out high exactly one cycle after the 8th beat.
- q=k=(-128,-128,-128,-128) -> sum 65536, s=32768, mst_data_out=127, mst_sat_out=1; q=(-128 ×4), k=(127 ×4) -> s=-32512, mst_data_out=-128, mst_sat_out=1.
- q=(-3,0,0,0), k=(1,0,0,0) -> s=-2 (floor), mst_data_out=-2, mst_sat_out=0.
- mst_rdy_in=0, stream two vectors back-to-back -> first score held stable; slv_rdy_out drops only on the second vector's last k beat; raising mst_rdy_in drains score 1 and accepts that beat in the same cycle, score 2 valid next cycle.
- Assert rst_n low after 5 beats -> all outputs at reset values immediately; fresh vector (1,2,3,4)/(5,6,7,8) then yields 35.
- Random vld/rdy toggling, NUM_FEAT=8, DATA_W=6, SHIFT=3, OUT_W=10 -> every score matches reference model, none lost or duplicated.
